cmd_rx: RTL and testbench

//   SUMP command assembler between the UART receiver and the instruction decoder (indec).
//   - Collects received bytes into complete SUMP commands: 1 opcode byte, plus 4 argument bytes when opc[7]=1.
//   - Presents each completed command as a one-cycle strobe with opcode and 32-bit argument.
//   - Discards partial long commands that stall beyond a timeout.

---
 rtl/cmd_rx.sv | 115 +++++++++++
 tb/tb_cmd_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_rx.sv
// SUMP command assembler: gathers UART bytes into opcode + 32-bit argument
// commands and strobes each completed command to the instruction decoder.
module cmd_rx #(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stb_i,
   input  logic [7:0]  data_i,
   output logic        stb_o,
   output logic [7:0]  opc_o,
   output logic [31:0] cmd_o,
   output logic        busy_o,
   output logic        tmo_o
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TLIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TW-1:0] TLIM = TLIM_I[TW-1:0];

   typedef enum logic {IDLE, ARGS} state_t;

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [TW-1:0] timer, timer_nx, timer_inc;
   logic [7:0]  opc_sh, opc_sh_nx;
   logic [31:0] arg_sh, arg_sh_nx;
   logic        done, expire;
   logic [7:0]  done_opc;
   logic [31:0] done_cmd;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      timer_nx  = timer;
      opc_sh_nx = opc_sh;
      arg_sh_nx = arg_sh;
      done      = 1'b0;
      expire    = 1'b0;
      done_opc  = opc_sh;
      done_cmd  = arg_sh;
      // saturating increment so the timer never wraps
      timer_inc = (&timer) ? timer : timer + 1'b1;
      unique case (state)
         IDLE: begin
            if (stb_i) begin
               if (data_i[7]) begin
                  state_nx  = ARGS;
                  opc_sh_nx = data_i;
                  arg_sh_nx = '0;
                  cnt_nx    = 2'd0;
                  timer_nx  = '0;
               end else begin
                  done     = 1'b1;
                  done_opc = data_i;
                  done_cmd = '0;
               end
            end
         end
         ARGS: begin
            if (stb_i) begin
               arg_sh_nx[8*cnt +: 8] = data_i;
               cnt_nx   = cnt + 2'd1;
               timer_nx = '0;
               if (cnt == 2'd3) begin
                  done     = 1'b1;
                  done_opc = opc_sh;
                  done_cmd = {data_i, arg_sh[23:0]};
                  state_nx = IDLE;
               end
            end else begin
               timer_nx = timer_inc;
               if (TIMEOUT != 0 && timer_inc >= TLIM) begin
                  expire    = 1'b1;
                  state_nx  = IDLE;
                  timer_nx  = '0;
                  cnt_nx    = 2'd0;
                  opc_sh_nx = '0;
                  arg_sh_nx = '0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= 2'd0;
         timer  <= '0;
         opc_sh <= '0;
         arg_sh <= '0;
         stb_o  <= 1'b0;
         opc_o  <= '0;
         cmd_o  <= '0;
         busy_o <= 1'b0;
         tmo_o  <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         timer  <= timer_nx;
         opc_sh <= opc_sh_nx;
         arg_sh <= arg_sh_nx;
         stb_o  <= done;
         tmo_o  <= expire;
         busy_o <= (state_nx == ARGS);
         if (done) begin
            opc_o <= done_opc;
            cmd_o <= done_cmd;
         end
      end
   end

endmodule

// File: tb/tb_cmd_rx.sv
// Bench for cmd_rx: directed byte streams, scoreboard of expected
// commands and timeout pulses checked by a negedge monitor.
module tb_cmd_rx;

   localparam int unsigned TMO = 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stb_i;
   logic [7:0]  data_i;
   logic        stb_o;
   logic [7:0]  opc_o;
   logic [31:0] cmd_o;
   logic        busy_o;
   logic        tmo_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [39:0] sb[$];
   int          tmo_q[$];

   cmd_rx #(.TIMEOUT(TMO)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .stb_i (stb_i),
      .data_i(data_i),
      .stb_o (stb_o),
      .opc_o (opc_o),
      .cmd_o (cmd_o),
      .busy_o(busy_o),
      .tmo_o (tmo_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] act,
                      input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      stb_i  = 1'b1;
      data_i = b;
      @(negedge clk_i);
      stb_i  = 1'b0;
      data_i = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stb"}, {39'd0, stb_o}, 40'd0);
      chk({tag, "_opc"}, {32'd0, opc_o}, 40'd0);
      chk({tag, "_cmd"}, {8'd0, cmd_o}, 40'd0);
      chk({tag, "_busy"}, {39'd0, busy_o}, 40'd0);
      chk({tag, "_tmo"}, {39'd0, tmo_o}, 40'd0);
   endtask

   // monitor: every strobe/timeout pulse must match the scoreboard head
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (stb_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_stb", {opc_o, cmd_o}, 40'hxx_xxxxxxxx);
            end else begin
               chk("cmd", {opc_o, cmd_o}, sb.pop_front());
            end
         end
         if (tmo_o) begin
            if (tmo_q.size() == 0) begin
               chk("unexpected_tmo", 40'(cyc), 40'hxx_xxxxxxxx);
            end else begin
               chk("tmo_cycle", 40'(cyc), 40'(tmo_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      // bytes offered during reset must be ignored
      rst_i  = 1'b1;
      stb_i  = 1'b1;
      data_i = 8'h85;
      idle(3);
      chk_reset_vals("reset");
      stb_i  = 1'b0;
      data_i = 8'h00;
      rst_i  = 1'b0;
      idle(2);

      // short command
      sb.push_back({8'h00, 32'h0});
      send(8'h00);
      chk("t1_busy", {39'd0, busy_o}, 40'd0);
      idle(2);

      // long command, little-endian argument
      send(8'hC0);
      chk("t2_busy0", {39'd0, busy_o}, 40'd1);
      send(8'h11);
      chk("t2_busy1", {39'd0, busy_o}, 40'd1);
      send(8'h22);
      send(8'h33);
      chk("t2_busy3", {39'd0, busy_o}, 40'd1);
      sb.push_back({8'hC0, 32'h44332211});
      send(8'h44);
      chk("t2_busy_end", {39'd0, busy_o}, 40'd0);
      idle(2);

      // stalled long command is dropped
      send(8'h82);
      send(8'hAA);
      n = cyc;
      tmo_q.push_back(n + 7);
      idle(6);
      chk("t3_busy_pre", {39'd0, busy_o}, 40'd1);
      idle(1);
      chk("t3_busy_post", {39'd0, busy_o}, 40'd0);
      sb.push_back({8'h01, 32'h0});
      send(8'h01);
      idle(2);

      // six idle cycles between bytes is just inside the limit
      send(8'h85);
      idle(6);
      send(8'h10);
      idle(6);
      send(8'h20);
      idle(6);
      send(8'h30);
      idle(6);
      sb.push_back({8'h85, 32'h40302010});
      send(8'h40);
      chk("t4_busy", {39'd0, busy_o}, 40'd0);
      idle(2);

      // back-to-back bytes, second command right after the strobe
      sb.push_back({8'hC0, 32'h04030201});
      sb.push_back({8'h02, 32'h0});
      send(8'hC0);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      send(8'h02);
      idle(2);

      // reset mid-command drops it silently
      send(8'hC0);
      send(8'h01);
      rst_i = 1'b1;
      idle(2);
      chk_reset_vals("t6_reset");
      rst_i = 1'b0;
      idle(1);
      sb.push_back({8'h11, 32'h0});
      send(8'h11);
      idle(int'(TMO) + 4);

      chk("sb_empty", 40'(sb.size()), 40'd0);
      chk("tmo_q_empty", 40'(tmo_q.size()), 40'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
